control_unit: RTL
=================

Name: control_unit

Overview:
- Microcode sequencer for the 8-bit computer.
- Steps through fetch and execute micro-steps and decodes the opcode held in the instruction register.
- Drives every bus/load strobe, including the program counter's count enable (o_ce), write enable (o_j) and output enable (o_co).
- Sits between the instruction register, flags register and all datapath registers; advances only on clock-enable ticks.

Parameters:
DATA_WIDTH, 8, width of instruction register input; opcode is i_instr[DATA_WIDTH-1 -: 4]
STEP_WIDTH, 3, width of micro-step counter (max 5 steps used)

Ports:
i_clk  input  1  clock
i_reset  input  1  reset, synchronous, active-high
i_clke  input  1  clock enable; state changes only when high
i_instr  input  DATA_WIDTH  instruction register contents
i_flag_c  input  1  carry flag
i_flag_z  input  1  zero flag
o_step  output  STEP_WIDTH  current micro-step (T0..T4)
o_halted  output  1  sequencer halted
o_hlt, o_mi, o_ri, o_ro, o_io, o_ii, o_ai, o_ao, o_eo, o_su, o_bi, o_oi, o_ce, o_co, o_j, o_fi  output  1 each  control strobes: halt, MAR in, RAM in/out, IR out/in, A in/out, ALU out, subtract, B in, output-reg in, PC count/out/jump, flags in

Behaviour:
- Reset: i_reset=1 at a posedge i_clk (regardless of i_clke) sets step=0 and halted=0. While i_reset=1, all strobes are forced to 0. o_step and o_halted are registered.
- Strobes are combinational decode of (step, opcode, flags). They take effect at the next clke edge. No extra latency.
- Fetch, identical for all opcodes:
  - T0: CO MI
  - T1: RO II CE
- Execute, from T2; opcode is the new IR value, loaded at the end of T1:
  - NOP 0x0: none, last=T1
  - LDA 0x1: T2 IO MI; T3 RO AI; last=T3
  - ADD 0x2: T2 IO MI; T3 RO BI; T4 EO AI FI; last=T4
  - SUB 0x3: as ADD, with SU also at T4
  - STA 0x4: T2 IO MI; T3 AO RI; last=T3
  - LDI 0x5: T2 IO AI; last=T2
  - JMP 0x6: T2 IO J; last=T2
  - JC 0x7: T2 IO J if i_flag_c else nothing; last=T2
  - JZ 0x8: T2 IO J if i_flag_z else nothing; last=T2
  - OUT 0xE: T2 AO OI; last=T2
  - HLT 0xF: T2 HLT; last=T2
  - 0x9-0xD: treated as NOP
- Step transition on i_clke=1: if step==last(opcode), step becomes 0; otherwise step+1.
  - Early termination means no idle steps.
  - step never exceeds 4.
- Halt:
  - A clke edge at T2 with opcode HLT sets halted=1 and step=0.
  - While halted: o_hlt=1, all other strobes 0, step frozen.
  - Only reset clears halted.
- Flags are sampled combinationally during T2 only. A flag change in other steps has no effect.
- i_clke=0: state holds. Strobes remain asserted, since they are level signals, but datapath registers gate on clke.
- Simultaneous i_reset and i_clke: reset wins.
- Reset mid-instruction: abort, resume at T0 fetch.
- Exactly one of o_co/o_ce/o_j is asserted in any given step, or none. o_j and o_ce are never both 1.

Decomposition:
- Shared package/include control_defs holds:
  - opcode localparams (OP_NOP..OP_HLT)
  - control-word bit indices
  - CW_WIDTH=16
- Sub-module control_rom: combinational (opcode, step, c, z) -> {control word, last_step}.
- control_unit holds the step register, halted flag, reset gating and the output unpacking.

Test Plan:
- Reset, then 2 clke ticks with i_instr=0x00 (NOP) -> T0 shows co=mi=1; T1 shows ro=ii=ce=1; next tick o_step=0.
- i_instr=0x2E (ADD) -> T2 io=mi=1; T3 ro=bi=1; T4 eo=ai=fi=1, su=0; then o_step returns to 0. SUB 0x3E identical but su=1 at T4.
- JC 0x74 with i_flag_c=0 -> T2 all strobes 0, o_step 2->0. Repeat with i_flag_c=1 -> io=j=1, ce=0. Same pair for JZ 0x84 with i_flag_z.
- HLT 0xF0 -> after T2 edge, o_halted=1, o_hlt=1, o_step=0. Stays frozen for 10 clke ticks. i_reset=1 -> o_halted=0, o_step=0.
- i_clke=0 for 5 cycles during LDA T3 -> o_step stays 3, ro=ai remain 1. Then one clke tick -> o_step=0.
- i_reset asserted at STA T3 together with i_clke=1 -> all strobes 0 that cycle, o_step=0 next cycle. Opcodes 0x9-0xD each end after T1.

Source files
------------

// File: rtl/control_defs.sv
// Shared opcode and control-word definitions for the 8-bit computer sequencer.
package control_defs;

  localparam int unsigned CW_WIDTH = 16;
  localparam int unsigned OP_WIDTH = 4;

  localparam logic [OP_WIDTH-1:0] OP_NOP = 4'h0;
  localparam logic [OP_WIDTH-1:0] OP_LDA = 4'h1;
  localparam logic [OP_WIDTH-1:0] OP_ADD = 4'h2;
  localparam logic [OP_WIDTH-1:0] OP_SUB = 4'h3;
  localparam logic [OP_WIDTH-1:0] OP_STA = 4'h4;
  localparam logic [OP_WIDTH-1:0] OP_LDI = 4'h5;
  localparam logic [OP_WIDTH-1:0] OP_JMP = 4'h6;
  localparam logic [OP_WIDTH-1:0] OP_JC  = 4'h7;
  localparam logic [OP_WIDTH-1:0] OP_JZ  = 4'h8;
  localparam logic [OP_WIDTH-1:0] OP_OUT = 4'hE;
  localparam logic [OP_WIDTH-1:0] OP_HLT = 4'hF;

  // Control-word bit positions
  localparam int unsigned CW_HLT = 15;
  localparam int unsigned CW_MI  = 14;
  localparam int unsigned CW_RI  = 13;
  localparam int unsigned CW_RO  = 12;
  localparam int unsigned CW_IO  = 11;
  localparam int unsigned CW_II  = 10;
  localparam int unsigned CW_AI  = 9;
  localparam int unsigned CW_AO  = 8;
  localparam int unsigned CW_EO  = 7;
  localparam int unsigned CW_SU  = 6;
  localparam int unsigned CW_BI  = 5;
  localparam int unsigned CW_OI  = 4;
  localparam int unsigned CW_CE  = 3;
  localparam int unsigned CW_CO  = 2;
  localparam int unsigned CW_J   = 1;
  localparam int unsigned CW_FI  = 0;

endpackage

// File: rtl/control_rom.sv
// Microcode ROM: (opcode, step, flags) -> control word and last step of the opcode.
module control_rom
  import control_defs::*;
#(
  parameter int unsigned STEP_WIDTH = 3
) (
  input  logic [OP_WIDTH-1:0]   opcode_i,
  input  logic [STEP_WIDTH-1:0] step_i,
  input  logic                  flag_c_i,
  input  logic                  flag_z_i,
  output logic [CW_WIDTH-1:0]   cw_o,
  output logic [STEP_WIDTH-1:0] last_step_o
);

  // Final micro-step per opcode; unlisted opcodes behave as NOP
  always_comb begin
    last_step_o = STEP_WIDTH'(1);
    case (opcode_i)
      OP_NOP:                                       last_step_o = STEP_WIDTH'(1);
      OP_LDA, OP_STA:                               last_step_o = STEP_WIDTH'(3);
      OP_ADD, OP_SUB:                               last_step_o = STEP_WIDTH'(4);
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_step_o = STEP_WIDTH'(2);
      default:                                      last_step_o = STEP_WIDTH'(1);
    endcase
  end

  // Control word decode; flags only matter in T2 for conditional jumps
  always_comb begin
    cw_o = '0;
    case (step_i)
      STEP_WIDTH'(0): begin
        cw_o[CW_CO] = 1'b1;
        cw_o[CW_MI] = 1'b1;
      end
      STEP_WIDTH'(1): begin
        cw_o[CW_RO] = 1'b1;
        cw_o[CW_II] = 1'b1;
        cw_o[CW_CE] = 1'b1;
      end
      STEP_WIDTH'(2): begin
        case (opcode_i)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw_o[CW_IO] = 1'b1;
            cw_o[CW_MI] = 1'b1;
          end
          OP_LDI: begin
            cw_o[CW_IO] = 1'b1;
            cw_o[CW_AI] = 1'b1;
          end
          OP_JMP: begin
            cw_o[CW_IO] = 1'b1;
            cw_o[CW_J]  = 1'b1;
          end
          OP_JC: begin
            cw_o[CW_IO] = flag_c_i;
            cw_o[CW_J]  = flag_c_i;
          end
          OP_JZ: begin
            cw_o[CW_IO] = flag_z_i;
            cw_o[CW_J]  = flag_z_i;
          end
          OP_OUT: begin
            cw_o[CW_AO] = 1'b1;
            cw_o[CW_OI] = 1'b1;
          end
          OP_HLT:  cw_o[CW_HLT] = 1'b1;
          default: cw_o = '0;
        endcase
      end
      STEP_WIDTH'(3): begin
        case (opcode_i)
          OP_LDA: begin
            cw_o[CW_RO] = 1'b1;
            cw_o[CW_AI] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw_o[CW_RO] = 1'b1;
            cw_o[CW_BI] = 1'b1;
          end
          OP_STA: begin
            cw_o[CW_AO] = 1'b1;
            cw_o[CW_RI] = 1'b1;
          end
          default: cw_o = '0;
        endcase
      end
      STEP_WIDTH'(4): begin
        if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
          cw_o[CW_EO] = 1'b1;
          cw_o[CW_AI] = 1'b1;
          cw_o[CW_FI] = 1'b1;
          cw_o[CW_SU] = (opcode_i == OP_SUB);
        end
      end
      default: cw_o = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Microcode sequencer: step counter, halt latch, reset gating and strobe unpacking.
module control_unit
  import control_defs::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STEP_WIDTH = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clke,
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic                  i_flag_c,
  input  logic                  i_flag_z,
  output logic [STEP_WIDTH-1:0] o_step,
  output logic                  o_halted,
  output logic                  o_hlt,
  output logic                  o_mi,
  output logic                  o_ri,
  output logic                  o_ro,
  output logic                  o_io,
  output logic                  o_ii,
  output logic                  o_ai,
  output logic                  o_ao,
  output logic                  o_eo,
  output logic                  o_su,
  output logic                  o_bi,
  output logic                  o_oi,
  output logic                  o_ce,
  output logic                  o_co,
  output logic                  o_j,
  output logic                  o_fi
);

  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic                  halted_q, halted_d;
  logic [OP_WIDTH-1:0]   opcode;
  logic [CW_WIDTH-1:0]   rom_cw, cw;
  logic [STEP_WIDTH-1:0] last_step;
  logic                  unused_instr_bits;

  assign opcode            = i_instr[DATA_WIDTH-1 -: OP_WIDTH];
  assign unused_instr_bits = ^i_instr[DATA_WIDTH-OP_WIDTH-1:0];

  control_rom #(.STEP_WIDTH(STEP_WIDTH)) u_rom (
    .opcode_i    (opcode),
    .step_i      (step_q),
    .flag_c_i    (i_flag_c),
    .flag_z_i    (i_flag_z),
    .cw_o        (rom_cw),
    .last_step_o (last_step)
  );

  // Step / halt registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      step_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Next step: wrap after the opcode's last step, freeze while halted
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (i_clke && !halted_q) begin
      if (step_q == last_step) begin
        step_d = '0;
      end else begin
        step_d = step_q + STEP_WIDTH'(1);
      end
      if (step_q == STEP_WIDTH'(2) && opcode == OP_HLT) begin
        halted_d = 1'b1;
        step_d   = '0;
      end
    end
  end

  // Strobe gating: reset clears everything, halt leaves only HLT
  always_comb begin
    cw = rom_cw;
    if (halted_q) begin
      cw         = '0;
      cw[CW_HLT] = 1'b1;
    end
    if (i_reset) begin
      cw = '0;
    end
  end

  assign o_step   = step_q;
  assign o_halted = halted_q;

  assign o_hlt = cw[CW_HLT];
  assign o_mi  = cw[CW_MI];
  assign o_ri  = cw[CW_RI];
  assign o_ro  = cw[CW_RO];
  assign o_io  = cw[CW_IO];
  assign o_ii  = cw[CW_II];
  assign o_ai  = cw[CW_AI];
  assign o_ao  = cw[CW_AO];
  assign o_eo  = cw[CW_EO];
  assign o_su  = cw[CW_SU];
  assign o_bi  = cw[CW_BI];
  assign o_oi  = cw[CW_OI];
  assign o_ce  = cw[CW_CE];
  assign o_co  = cw[CW_CO];
  assign o_j   = cw[CW_J];
  assign o_fi  = cw[CW_FI];

endmodule
